cpx_multiply_arbiter: RTL and testbench
=======================================

Name: cpx_multiply_arbiter

Overview:
- Shares one pipelined complex multiplier (cpx_multiply) between two requesters, A and B.
- Arbitrates round-robin and registers the winning operands onto the multiplier's m_axis_x/y inputs.
- Tracks outstanding products in a tag FIFO and returns each product on a shared result bus, labelled with its requester ID.
- Sits between CAF channel datapaths and the single multiplier instance.

Parameters:
- IN_BITS, 16: width of each operand component (xi, xq, yi, yq).
- OUT_BITS, 33: width of each multiplier output component (i_out, q_out).
- TAG_DEPTH, 8: maximum outstanding products; power of 2, at least 2.
- TAG_AW, 3: log2(TAG_DEPTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has an operand set
- a_ready  out  1  requester A is granted this cycle
- a_xi, a_xq, a_yi, a_yq  in  IN_BITS each  requester A operands, signed
- b_valid, b_ready, b_xi, b_xq, b_yi, b_yq: same as A, for requester B
- m_axis_x_tvalid  out  1  to multiplier
- m_axis_y_tvalid  out  1  to multiplier
- xi, xq, yi, yq  out  IN_BITS each  to multiplier, signed
- s_axis_i_tvalid  in  1  from multiplier
- s_axis_q_tvalid  in  1  from multiplier
- i_out, q_out  in  OUT_BITS each  from multiplier, signed
- res_valid  out  1  product valid, single-cycle pulse
- res_id  out  1  0 = A, 1 = B
- res_i, res_q  out  OUT_BITS each  product
- err_underflow  out  1  sticky: multiplier produced output with no pending tag

Behaviour:
- Reset (async assert, sync deassert): clears all output registers, the tag FIFO (count 0), last_grant (reset 1, so A wins the first tie) and err_underflow.
- Reset mid-operation: in-flight products are discarded and tags are lost. Products emitted later by the multiplier raise err_underflow.
- can_issue = (tag count < TAG_DEPTH) or pop this cycle.
- Grant, combinational:
  - If not can_issue: no grant.
  - Else if only one requester is valid: grant it.
  - Else if both are valid: grant the requester other than last_grant.
  - a_ready/b_ready = grant, and are never both high.
  - a_ready/b_ready do not depend on the requester's own valid beyond the arbitration above.
- Transfer occurs when valid and ready are both high. On a transfer:
  - The winner's operands are registered onto xi/xq/yi/yq.
  - m_axis_x_tvalid and m_axis_y_tvalid both go high the next cycle.
  - The tag (winner ID) is pushed to the FIFO.
  - last_grant is updated to the winner.
- No transfer: both tvalids go low the next cycle; operand registers hold their values.
- Issue latency: 1 cycle from the valid/ready transfer to the multiplier input.
- Throughput: 1 product per cycle. Two continuously valid requesters alternate A, B, A, B.
- Return path, on s_axis_i_tvalid & s_axis_q_tvalid:
  - If FIFO is non-empty: pop the head tag. Register res_valid=1, res_id=tag, res_i=i_out, res_q=q_out the next cycle.
  - If FIFO is empty: set err_underflow, keep res_valid low, drop the data.
- Only one of the two s_axis valids high: treated as no output.
- res_valid is low in any cycle without a pop.
- Simultaneous push and pop: both occur and the count is unchanged. At full, a same-cycle pop permits a push.
- Pointer wrap: natural modulo TAG_DEPTH.
- Results carry no backpressure and must be accepted when presented.

Optional Feature:
- Macro CPX_ARB_STATS_EN.
- Defined: adds outputs stat_a_cnt and stat_b_cnt, 32 bits each. Each increments on that requester's transfer, wraps at 2^32, and resets to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package cpx_arb_pkg:
  - ID constants ID_A=0, ID_B=1.
  - Default widths IN_BITS=16, OUT_BITS=33, TAG_DEPTH=8.
- Sub-module cpx_arb_tag_fifo: 1-bit-wide synchronous FIFO.
  - Inputs: push, pop.
  - Outputs: head, count, empty, full.
  - Depth TAG_DEPTH, with the same reset as the parent.

Test Plan:
- A only: a_xi=3, a_xq=4, a_yi=3, a_yq=-4; multiplier returns 25,0 after latency → res_valid pulse with res_id=0, res_i=25, res_q=0; err_underflow stays 0.
- A and B valid continuously for 6 cycles from reset → grants A,B,A,B,A,B; result IDs return in the same order.
- Hold s_axis valids low until 8 products are outstanding → a_ready=b_ready=0. Assert one multiplier output → a grant is allowed in that same cycle.
- Multiplier output with FIFO empty (i_out=7) → res_valid stays 0, err_underflow=1 and remains set until rst_n is asserted.
- Drop rst_n with 3 products outstanding → all outputs and count are 0 immediately. The next A request is granted in the first cycle after reset release.
- With CPX_ARB_STATS_EN defined, run 5 A and 3 B transfers → stat_a_cnt=5, stat_b_cnt=3.

Source files
------------

// File: rtl/cpx_arb_pkg.sv
// Shared constants for the complex-multiplier arbiter: requester IDs and default widths.
package cpx_arb_pkg;

   localparam int IN_BITS_DEF   = 16;
   localparam int OUT_BITS_DEF  = 33;
   localparam int TAG_DEPTH_DEF = 8;
   localparam int TAG_AW_DEF    = 3;

   typedef enum logic {
      ID_A = 1'b0,
      ID_B = 1'b1
   } req_id_e;

endpackage

// File: rtl/cpx_arb_tag_fifo.sv
// 1-bit-wide tag FIFO holding the requester ID of every product still inside the multiplier.
module cpx_arb_tag_fifo
   import cpx_arb_pkg::*;
#(
   parameter int DEPTH = TAG_DEPTH_DEF,
   parameter int AW    = TAG_AW_DEF
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          din,
   input  logic          pop,
   output logic          head,
   output logic [AW:0]   count,
   output logic          empty,
   output logic          full
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/cpx_multiply_arbiter.sv
// Round-robin sharing of one pipelined complex multiplier between requesters A and B.
// Optional per-requester transfer counters are built when CPX_ARB_STATS_EN is defined.
module cpx_multiply_arbiter
   import cpx_arb_pkg::*;
#(
   parameter int IN_BITS   = IN_BITS_DEF,
   parameter int OUT_BITS  = OUT_BITS_DEF,
   parameter int TAG_DEPTH = TAG_DEPTH_DEF,
   parameter int TAG_AW    = TAG_AW_DEF
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       a_valid,
   output logic                       a_ready,
   input  logic signed [IN_BITS-1:0]  a_xi,
   input  logic signed [IN_BITS-1:0]  a_xq,
   input  logic signed [IN_BITS-1:0]  a_yi,
   input  logic signed [IN_BITS-1:0]  a_yq,
   input  logic                       b_valid,
   output logic                       b_ready,
   input  logic signed [IN_BITS-1:0]  b_xi,
   input  logic signed [IN_BITS-1:0]  b_xq,
   input  logic signed [IN_BITS-1:0]  b_yi,
   input  logic signed [IN_BITS-1:0]  b_yq,
   output logic                       m_axis_x_tvalid,
   output logic                       m_axis_y_tvalid,
   output logic signed [IN_BITS-1:0]  xi,
   output logic signed [IN_BITS-1:0]  xq,
   output logic signed [IN_BITS-1:0]  yi,
   output logic signed [IN_BITS-1:0]  yq,
   input  logic                       s_axis_i_tvalid,
   input  logic                       s_axis_q_tvalid,
   input  logic signed [OUT_BITS-1:0] i_out,
   input  logic signed [OUT_BITS-1:0] q_out,
   output logic                       res_valid,
   output logic                       res_id,
   output logic signed [OUT_BITS-1:0] res_i,
   output logic signed [OUT_BITS-1:0] res_q,
   output logic                       err_underflow
`ifdef CPX_ARB_STATS_EN
   ,
   output logic [31:0]                stat_a_cnt,
   output logic [31:0]                stat_b_cnt
`endif
);

   localparam logic [TAG_AW:0] FULL_CNT = (TAG_AW+1)'(TAG_DEPTH);

   logic            ret_valid;
   logic            pop;
   logic            push;
   logic            can_issue;
   logic            grant_a;
   logic            grant_b;
   req_id_e         win_id;
   req_id_e         last_grant;
   logic            tag_head;
   logic            tag_empty;
   logic            tag_full;
   logic [TAG_AW:0] tag_count;

   assign ret_valid = s_axis_i_tvalid & s_axis_q_tvalid;
   assign pop       = ret_valid & ~tag_empty;
   assign can_issue = ~tag_full | pop;

   // Round-robin: on a tie the requester that did not win last time gets the slot.
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (can_issue) begin
         if (a_valid && b_valid) begin
            if (last_grant == ID_A) grant_b = 1'b1;
            else                    grant_a = 1'b1;
         end else if (a_valid) begin
            grant_a = 1'b1;
         end else if (b_valid) begin
            grant_b = 1'b1;
         end
      end
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;
   assign push    = grant_a | grant_b;
   assign win_id  = grant_b ? ID_B : ID_A;

   cpx_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .AW    (TAG_AW)
   ) u_tag_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (win_id),
      .pop   (pop),
      .head  (tag_head),
      .count (tag_count),
      .empty (tag_empty),
      .full  (tag_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_x_tvalid <= 1'b0;
         m_axis_y_tvalid <= 1'b0;
         xi              <= '0;
         xq              <= '0;
         yi              <= '0;
         yq              <= '0;
         last_grant      <= ID_B;
      end else begin
         m_axis_x_tvalid <= push;
         m_axis_y_tvalid <= push;
         if (push) begin
            xi         <= grant_b ? b_xi : a_xi;
            xq         <= grant_b ? b_xq : a_xq;
            yi         <= grant_b ? b_yi : a_yi;
            yq         <= grant_b ? b_yq : a_yq;
            last_grant <= win_id;
         end
      end
   end

   // A product arriving with no pending tag is dropped and flagged until the next reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid     <= 1'b0;
         res_id        <= 1'b0;
         res_i         <= '0;
         res_q         <= '0;
         err_underflow <= 1'b0;
      end else begin
         res_valid <= pop;
         if (pop) begin
            res_id <= tag_head;
            res_i  <= i_out;
            res_q  <= q_out;
         end
         if (ret_valid && tag_empty) begin
            err_underflow <= 1'b1;
         end
      end
   end

`ifdef CPX_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_a_cnt <= '0;
         stat_b_cnt <= '0;
      end else begin
         if (grant_a) stat_a_cnt <= stat_a_cnt + 32'd1;
         if (grant_b) stat_b_cnt <= stat_b_cnt + 32'd1;
      end
   end
`endif

   assert property (@(posedge clk) disable iff (!rst_n) tag_count <= FULL_CNT);
   assert property (@(posedge clk) disable iff (!rst_n) !(a_ready && b_ready));

endmodule

// File: tb/tb_cpx_multiply_arbiter.sv
// Scoreboard bench for cpx_multiply_arbiter with a behavioural pipelined multiplier.
// Stat counter checks are built when CPX_ARB_STATS_EN is defined.
module tb_cpx_multiply_arbiter;
   import cpx_arb_pkg::*;

   localparam int MUL_LAT = 3;

   typedef struct {
      logic               id;
      logic signed [32:0] pi;
      logic signed [32:0] pq;
   } exp_t;

   typedef struct {
      logic signed [32:0] pi;
      logic signed [32:0] pq;
      int                 due;
   } pend_t;

   logic clk = 1'b0;
   logic rst_n;
   logic a_valid, a_ready, b_valid, b_ready;
   logic signed [15:0] a_xi, a_xq, a_yi, a_yq;
   logic signed [15:0] b_xi, b_xq, b_yi, b_yq;
   logic m_axis_x_tvalid, m_axis_y_tvalid;
   logic signed [15:0] xi, xq, yi, yq;
   logic s_axis_i_tvalid, s_axis_q_tvalid;
   logic signed [32:0] i_out, q_out;
   logic res_valid, res_id;
   logic signed [32:0] res_i, res_q;
   logic err_underflow;
`ifdef CPX_ARB_STATS_EN
   logic [31:0] stat_a_cnt, stat_b_cnt;
`endif

   int    tests_run = 0;
   int    tests_failed = 0;
   int    cyc = 0;
   int    xfer_cnt = 0;
   bit    mul_auto = 1'b1;
   bit    stall_en = 1'b0;
   exp_t  exp_q[$];
   pend_t pend_q[$];
   logic  grant_log[$];

   always #5 clk = ~clk;

   cpx_multiply_arbiter dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .a_valid         (a_valid),
      .a_ready         (a_ready),
      .a_xi            (a_xi),
      .a_xq            (a_xq),
      .a_yi            (a_yi),
      .a_yq            (a_yq),
      .b_valid         (b_valid),
      .b_ready         (b_ready),
      .b_xi            (b_xi),
      .b_xq            (b_xq),
      .b_yi            (b_yi),
      .b_yq            (b_yq),
      .m_axis_x_tvalid (m_axis_x_tvalid),
      .m_axis_y_tvalid (m_axis_y_tvalid),
      .xi              (xi),
      .xq              (xq),
      .yi              (yi),
      .yq              (yq),
      .s_axis_i_tvalid (s_axis_i_tvalid),
      .s_axis_q_tvalid (s_axis_q_tvalid),
      .i_out           (i_out),
      .q_out           (q_out),
      .res_valid       (res_valid),
      .res_id          (res_id),
      .res_i           (res_i),
      .res_q           (res_q),
      .err_underflow   (err_underflow)
`ifdef CPX_ARB_STATS_EN
      ,
      .stat_a_cnt      (stat_a_cnt),
      .stat_b_cnt      (stat_b_cnt)
`endif
   );

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t mkExp(input logic id, input logic signed [15:0] p, input logic signed [15:0] q,
                                  input logic signed [15:0] r, input logic signed [15:0] s);
      longint vi, vq;
      exp_t   e;
      vi = longint'(p) * longint'(r) - longint'(q) * longint'(s);
      vq = longint'(p) * longint'(s) + longint'(q) * longint'(r);
      e.id = id;
      e.pi = vi[32:0];
      e.pq = vq[32:0];
      return e;
   endfunction

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic av, input int axi, input int axq, input int ayi, input int ayq,
                                input logic bv, input int bxi, input int bxq, input int byi, input int byq);
      a_valid = av;
      a_xi = axi[15:0]; a_xq = axq[15:0]; a_yi = ayi[15:0]; a_yq = ayq[15:0];
      b_valid = bv;
      b_xi = bxi[15:0]; b_xq = bxq[15:0]; b_yi = byi[15:0]; b_yq = byq[15:0];
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      stepCycle();
      stepCycle();
      exp_q.delete();
      pend_q.delete();
      grant_log.delete();
      rst_n = 1'b1;
   endtask

   task automatic waitDrain(input string tag, input int max_cycles);
      for (int k = 0; k < max_cycles; k++) begin
         if (exp_q.size() == 0 && pend_q.size() == 0) break;
         stepCycle();
      end
      checkOutput(tag, exp_q.size(), 0);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard push on handshakes, multiplier capture, and result comparison.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_valid && a_ready) begin
            exp_q.push_back(mkExp(ID_A, a_xi, a_xq, a_yi, a_yq));
            grant_log.push_back(ID_A);
            xfer_cnt++;
         end
         if (b_valid && b_ready) begin
            exp_q.push_back(mkExp(ID_B, b_xi, b_xq, b_yi, b_yq));
            grant_log.push_back(ID_B);
            xfer_cnt++;
         end
         if (a_ready && b_ready) checkOutput("both_ready", 1, 0);
         if (m_axis_x_tvalid && m_axis_y_tvalid) begin
            pend_t p;
            exp_t  m;
            m = mkExp(1'b0, xi, xq, yi, yq);
            p.pi = m.pi;
            p.pq = m.pq;
            p.due = cyc + MUL_LAT;
            pend_q.push_back(p);
         end
         if (res_valid) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_res", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checkOutput("res_id", res_id, e.id);
               checkOutput("res_i", res_i, e.pi);
               checkOutput("res_q", res_q, e.pq);
            end
         end
      end
   end

   // Behavioural multiplier output stage, active while mul_auto is set.
   always @(posedge clk) begin
      #1;
      if (mul_auto) begin
         if (pend_q.size() > 0 && pend_q[0].due <= cyc && !(stall_en && $urandom_range(0, 3) == 0)) begin
            pend_t p;
            p = pend_q.pop_front();
            s_axis_i_tvalid = 1'b1;
            s_axis_q_tvalid = 1'b1;
            i_out = p.pi;
            q_out = p.pq;
         end else begin
            s_axis_i_tvalid = 1'b0;
            s_axis_q_tvalid = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int start;
      rst_n = 1'b0;
      s_axis_i_tvalid = 1'b0;
      s_axis_q_tvalid = 1'b0;
      i_out = '0;
      q_out = '0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle();
      stepCycle();
      checkOutput("rst_res_valid", res_valid, 0);
      checkOutput("rst_tvalid", m_axis_x_tvalid, 0);
      checkOutput("rst_err", err_underflow, 0);
      checkOutput("rst_xi", xi, 0);
      rst_n = 1'b1;

      // Single A request: 3+4j times 3-4j.
      applyStimulus(1, 3, 4, 3, -4, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t1_a_ready", a_ready, 1);
      stepCycle();
      a_valid = 1'b0;
      checkOutput("t1_x_tvalid", m_axis_x_tvalid, 1);
      checkOutput("t1_y_tvalid", m_axis_y_tvalid, 1);
      checkOutput("t1_xi", xi, 16'sd3);
      checkOutput("t1_yq", yq, -16'sd4);
      stepCycle();
      checkOutput("t1_tvalid_low", m_axis_x_tvalid, 0);
      checkOutput("t1_xi_hold", xi, 16'sd3);
      waitDrain("t1_drain", 30);
      checkOutput("t1_err", err_underflow, 0);

      // Both requesters valid for six cycles from reset.
      doReset();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1, i + 1, -i, 2, 5, 1, 7, i * 3, -2, i);
         stepCycle();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      checkOutput("t2_grants", grant_log.size(), 6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
         checkOutput("t2_order", grant_log[i], logic'(i % 2));
      end
      waitDrain("t2_drain", 40);

      // Fill the tag FIFO, then release one product.
      doReset();
      mul_auto = 1'b0;
      s_axis_i_tvalid = 1'b0;
      s_axis_q_tvalid = 1'b0;
      start = xfer_cnt;
      applyStimulus(1, 100, -200, 300, 50, 1, -7, 9, 11, -13);
      for (int k = 0; k < 20; k++) begin
         stepCycle();
         if (xfer_cnt - start >= 8) break;
      end
      checkOutput("t3_outstanding", xfer_cnt - start, 8);
      @(negedge clk);
      checkOutput("t3_full_a_ready", a_ready, 0);
      checkOutput("t3_full_b_ready", b_ready, 0);
      stepCycle();
      checkOutput("t3_pend_avail", pend_q.size() > 0, 1);
      if (pend_q.size() > 0) begin
         pend_t p;
         p = pend_q.pop_front();
         i_out = p.pi;
         q_out = p.pq;
         s_axis_i_tvalid = 1'b1;
         s_axis_q_tvalid = 1'b1;
      end
      @(negedge clk);
      checkOutput("t3_pop_grant_a", a_ready, 1);
      checkOutput("t3_pop_grant_b", b_ready, 0);
      stepCycle();
      s_axis_i_tvalid = 1'b0;
      s_axis_q_tvalid = 1'b0;
      a_valid = 1'b0;
      b_valid = 1'b0;
      stepCycle();
      mul_auto = 1'b1;
      waitDrain("t3_drain", 60);

      // Output with no pending tag, and a lone i-valid that must be ignored.
      doReset();
      mul_auto = 1'b0;
      stepCycle();
      s_axis_i_tvalid = 1'b1;
      i_out = 33'sd7;
      q_out = 33'sd0;
      stepCycle();
      s_axis_i_tvalid = 1'b0;
      @(negedge clk);
      checkOutput("t4_half_err", err_underflow, 0);
      stepCycle();
      s_axis_i_tvalid = 1'b1;
      s_axis_q_tvalid = 1'b1;
      stepCycle();
      s_axis_i_tvalid = 1'b0;
      s_axis_q_tvalid = 1'b0;
      @(negedge clk);
      checkOutput("t4_res_valid", res_valid, 0);
      checkOutput("t4_err_set", err_underflow, 1);
      repeat (5) stepCycle();
      checkOutput("t4_err_sticky", err_underflow, 1);
      rst_n = 1'b0;
      #1;
      checkOutput("t4_err_cleared", err_underflow, 0);
      doReset();

      // Reset with three products outstanding.
      applyStimulus(1, 1, 2, 3, 4, 0, 0, 0, 0, 0);
      repeat (3) stepCycle();
      a_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("t5_x_tvalid", m_axis_x_tvalid, 0);
      checkOutput("t5_res_valid", res_valid, 0);
      checkOutput("t5_xi", xi, 0);
      checkOutput("t5_count", dut.u_tag_fifo.count, 0);
      stepCycle();
      exp_q.delete();
      pend_q.delete();
      rst_n = 1'b1;
      applyStimulus(1, -5, 6, 7, -8, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkOutput("t5_first_grant", a_ready, 1);
      stepCycle();
      a_valid = 1'b0;
      stepCycle();
      mul_auto = 1'b1;
      waitDrain("t5_drain", 30);
      checkOutput("t5_err", err_underflow, 0);

`ifdef CPX_ARB_STATS_EN
      doReset();
      checkOutput("t6_stat_rst", stat_a_cnt, 0);
      applyStimulus(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      repeat (5) stepCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 2, 2, 2, 2);
      repeat (3) stepCycle();
      b_valid = 1'b0;
      stepCycle();
      checkOutput("t6_stat_a", stat_a_cnt, 5);
      checkOutput("t6_stat_b", stat_b_cnt, 3);
      waitDrain("t6_drain", 40);
`endif

      // Random traffic with a stalling multiplier.
      doReset();
      stall_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         applyStimulus($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom,
                       $urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom);
         stepCycle();
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      waitDrain("rand_drain", 200);
      checkOutput("rand_err", err_underflow, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
